// File: rtl/fifo_free_list.sv
// FWFT data FIFO plus a free list of small integer IDs, both built from one
// circular-buffer queue. The free-list instance comes out of reset holding every ID in order.

module ffl_queue #(
  parameter int W       = 32,
  parameter int LD      = 4,
  parameter bit PRELOAD = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [LD:0]   size
);
  localparam int         D   = 1 << LD;
  localparam logic [LD:0] CAP = (LD+1)'(D);

  logic [D-1:0][W-1:0] mem;
  logic [LD-1:0]       rptr, wptr;
  logic [LD:0]         cnt;
  logic                push, pop;

  // Acceptance depends only on the registered occupancy, so a push into a
  // full queue is dropped even when a pop frees a slot in the same cycle.
  assign push = wr_en && (cnt != CAP);
  assign pop  = rd_en && (cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= PRELOAD ? CAP : '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  generate
    if (PRELOAD) begin : g_preload
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < D; i++) mem[i] <= W'(i);
        end else if (push) begin
          mem[wptr] <= wr_data;
        end
      end
    end else begin : g_plain
      always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
      end
    end
  endgenerate

  assign rd_data = mem[rptr];
  assign size    = cnt;
endmodule

module fifo_free_list #(
  parameter int WIDTH        = 32,
  parameter int LOG_DEPTH    = 4,
  parameter int FL_LOG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    fifo_wr_en,
  input  logic [WIDTH-1:0]        fifo_wr_data,
  input  logic                    fifo_rd_en,
  output logic [WIDTH-1:0]        fifo_rd_data,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [LOG_DEPTH:0]      fifo_size,
  input  logic                    fl_wr_en,
  input  logic [FL_LOG_DEPTH-1:0] fl_wr_data,
  input  logic                    fl_rd_en,
  output logic [FL_LOG_DEPTH-1:0] fl_rd_data,
  output logic                    fl_full,
  output logic                    fl_empty
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int NIDS  = 1 << FL_LOG_DEPTH;

  logic [FL_LOG_DEPTH:0] fl_size;

  ffl_queue #(.W(WIDTH), .LD(LOG_DEPTH), .PRELOAD(1'b0)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .size    (fifo_size)
  );

  // ID width equals the pointer width, so the preload value of slot i is i.
  ffl_queue #(.W(FL_LOG_DEPTH), .LD(FL_LOG_DEPTH), .PRELOAD(1'b1)) u_fl (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (fl_wr_en),
    .wr_data (fl_wr_data),
    .rd_en   (fl_rd_en),
    .rd_data (fl_rd_data),
    .size    (fl_size)
  );

  assign fifo_full  = (fifo_size == (LOG_DEPTH+1)'(DEPTH));
  assign fifo_empty = (fifo_size == '0);
  assign fl_full    = (fl_size == (FL_LOG_DEPTH+1)'(NIDS));
  assign fl_empty   = (fl_size == '0);
endmodule

// File: tb/tb_fifo_free_list.sv
// Bench for fifo_free_list: directed scenarios plus random traffic checked
// against queue-based models of both the data FIFO and the ID free list.

module tb_fifo_free_list;
  logic        clk = 1'b0;
  logic        rstn;
  logic        fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [31:0] fifo_wr_data, fifo_rd_data;
  logic [4:0]  fifo_size;
  logic        fl_wr_en, fl_rd_en, fl_full, fl_empty;
  logic [3:0]  fl_wr_data, fl_rd_data;

  fifo_free_list #(.WIDTH(32), .LOG_DEPTH(4), .FL_LOG_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_size(fifo_size),
    .fl_wr_en(fl_wr_en), .fl_wr_data(fl_wr_data), .fl_rd_en(fl_rd_en),
    .fl_rd_data(fl_rd_data), .fl_full(fl_full), .fl_empty(fl_empty)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  logic [31:0] fq[$];
  logic [3:0]  lq[$];
  logic [3:0]  held[$];

  // Drive one clock cycle of stimulus starting 1ns after an edge; returns
  // what the consumer sees on the read ports before the edge and updates models.
  task automatic cycle(input logic fw, input logic [31:0] fwd, input logic fr,
                       input logic lw, input logic [3:0] lwd, input logic lr,
                       output logic [31:0] fseen, output logic [3:0] lseen);
    int fsz, lsz;
    fifo_wr_en = fw; fifo_wr_data = fwd; fifo_rd_en = fr;
    fl_wr_en = lw; fl_wr_data = lwd; fl_rd_en = lr;
    #1;
    fseen = fifo_rd_data;
    lseen = fl_rd_data;
    fsz = fq.size();
    lsz = lq.size();
    if (fr && fsz != 0)  void'(fq.pop_front());
    if (fw && fsz != 16) fq.push_back(fwd);
    if (lr && lsz != 0)  void'(lq.pop_front());
    if (lw && lsz != 16) lq.push_back(lwd);
    @(posedge clk); #1;
    fifo_wr_en = 1'b0; fifo_rd_en = 1'b0; fl_wr_en = 1'b0; fl_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #12;
    rstn = 1'b1;
    @(posedge clk); #1;
    fq.delete(); lq.delete(); held.delete();
    for (int i = 0; i < 16; i++) lq.push_back(4'(i));
  endtask

  task automatic test_reset();
    logic [31:0] fs; logic [3:0] ls;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 4'd0, 1'b1, fs, ls);
    #2 rstn = 1'b0;
    #1;
    n_total++; if (fifo_empty !== 1'b1) $display("FAIL reset_fifo_empty: got %b want 1", fifo_empty); else n_pass++;
    n_total++; if (fifo_size !== 5'd0) $display("FAIL reset_fifo_size: got %0d want 0", fifo_size); else n_pass++;
    n_total++; if (fifo_full !== 1'b0) $display("FAIL reset_fifo_full: got %b want 0", fifo_full); else n_pass++;
    n_total++; if (fl_full !== 1'b1 || fl_empty !== 1'b0) $display("FAIL reset_fl_flags: got full=%b empty=%b want 1/0", fl_full, fl_empty); else n_pass++;
    n_total++; if (fl_rd_data !== 4'd0) $display("FAIL reset_fl_rd_data: got %0d want 0", fl_rd_data); else n_pass++;
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    fq.delete(); lq.delete(); held.delete();
    for (int i = 0; i < 16; i++) lq.push_back(4'(i));
  endtask

  task automatic test_fill_drain();
    logic [31:0] fs; logic [3:0] ls;
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 4'd0, 1'b0, fs, ls);
    n_total++; if (fifo_full !== 1'b1 || fifo_size !== 5'd16) $display("FAIL fill_full: got full=%b size=%0d want 1/16", fifo_full, fifo_size); else n_pass++;
    cycle(1'b1, 32'hAA, 1'b0, 1'b0, 4'd0, 1'b0, fs, ls);
    n_total++; if (fifo_size !== 5'd16) $display("FAIL fill_17th_ignored: got size=%0d want 16", fifo_size); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, fs, ls);
      n_total++; if (fs !== 32'h10 + 32'(i)) $display("FAIL drain_data[%0d]: got %h want %h", i, fs, 32'h10 + 32'(i)); else n_pass++;
    end
    n_total++; if (fifo_empty !== 1'b1 || fifo_size !== 5'd0) $display("FAIL drain_empty: got empty=%b size=%0d want 1/0", fifo_empty, fifo_size); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] fs, exp; logic [3:0] ls;
    do_reset();
    // Both ops at size 0: only the push lands.
    cycle(1'b1, 32'hCAFE0000, 1'b1, 1'b0, 4'd0, 1'b0, fs, ls);
    n_total++; if (fifo_size !== 5'd1 || fifo_rd_data !== 32'hCAFE0000) $display("FAIL simul_empty: got size=%0d data=%h want 1/cafe0000", fifo_size, fifo_rd_data); else n_pass++;
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 4'd0, 1'b0, fs, ls);
    exp = 32'hCAFE0000;
    cycle(1'b1, 32'h5555AAAA, 1'b1, 1'b0, 4'd0, 1'b0, fs, ls);
    n_total++; if (fifo_size !== 5'd5) $display("FAIL simul_size5: got %0d want 5", fifo_size); else n_pass++;
    n_total++; if (fs !== exp) $display("FAIL simul_pop5: got %h want %h", fs, exp); else n_pass++;
    while (fq.size() < 16) cycle(1'b1, $urandom, 1'b0, 1'b0, 4'd0, 1'b0, fs, ls);
    exp = fq[0];
    cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'd0, 1'b0, fs, ls);
    n_total++; if (fifo_size !== 5'd15 || fs !== exp) $display("FAIL simul_full: got size=%0d data=%h want 15/%h", fifo_size, fs, exp); else n_pass++;
    // Draining shows the push at full was dropped and order held.
    for (int i = 0; i < 15; i++) begin
      exp = fq[0];
      cycle(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, fs, ls);
      n_total++; if (fs !== exp) $display("FAIL simul_drain[%0d]: got %h want %h", i, fs, exp); else n_pass++;
    end
    n_total++; if (fifo_empty !== 1'b1) $display("FAIL simul_drained_empty: got %b want 1", fifo_empty); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] fs, exp; logic [3:0] ls;
    logic fw, fr;
    do_reset();
    cycle(1'b1, $urandom, 1'b0, 1'b0, 4'd0, 1'b0, fs, ls);
    for (int i = 0; i < 40; i++) begin
      fw = (fq.size() == 1) ? 1'b1 : (fq.size() == 3) ? 1'b0 : 1'($urandom);
      fr = (fq.size() == 3) ? 1'b1 : (fq.size() == 1) ? 1'b0 : 1'($urandom);
      exp = fq[0];
      cycle(fw, $urandom, fr, 1'b0, 4'd0, 1'b0, fs, ls);
      if (fr) begin
        n_total++; if (fs !== exp) $display("FAIL wrap_data[%0d]: got %h want %h", i, fs, exp); else n_pass++;
      end
      n_total++; if (fifo_size !== 5'(fq.size())) $display("FAIL wrap_size[%0d]: got %0d want %0d", i, fifo_size, fq.size()); else n_pass++;
    end
  endtask

  task automatic test_free_list();
    logic [31:0] fs; logic [3:0] ls;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, fs, ls);
      n_total++; if (ls !== 4'(i)) $display("FAIL fl_alloc[%0d]: got %0d want %0d", i, ls, i); else n_pass++;
    end
    n_total++; if (fl_empty !== 1'b1 || fl_full !== 1'b0) $display("FAIL fl_empty: got empty=%b full=%b want 1/0", fl_empty, fl_full); else n_pass++;
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, fs, ls);
    n_total++; if (fl_empty !== 1'b1) $display("FAIL fl_pop_empty_ignored: got empty=%b want 1", fl_empty); else n_pass++;
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'd7, 1'b0, fs, ls);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'd3, 1'b0, fs, ls);
    n_total++; if (fl_rd_data !== 4'd7 || fl_empty !== 1'b0) $display("FAIL fl_return_head: got %0d empty=%b want 7/0", fl_rd_data, fl_empty); else n_pass++;
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'd9, 1'b1, fs, ls);
    n_total++; if (ls !== 4'd7 || fl_rd_data !== 4'd3) $display("FAIL fl_simul: got popped=%0d head=%0d want 7/3", ls, fl_rd_data); else n_pass++;
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, fs, ls);
    n_total++; if (fl_rd_data !== 4'd9 || fl_empty !== 1'b0) $display("FAIL fl_simul_tail: got head=%0d empty=%b want 9/0", fl_rd_data, fl_empty); else n_pass++;
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, fs, ls);
    n_total++; if (fl_empty !== 1'b1) $display("FAIL fl_simul_occupancy: got empty=%b want 1", fl_empty); else n_pass++;
  endtask

  task automatic test_fwft();
    logic [31:0] fs; logic [3:0] ls;
    do_reset();
    cycle(1'b1, 32'h0BADF00D, 1'b0, 1'b0, 4'd0, 1'b0, fs, ls);
    n_total++; if (fifo_empty !== 1'b0 || fifo_rd_data !== 32'h0BADF00D) $display("FAIL fwft_visible: got empty=%b data=%h want 0/0badf00d", fifo_empty, fifo_rd_data); else n_pass++;
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, fs, ls);
    n_total++; if (fs !== 32'h0BADF00D || fifo_empty !== 1'b1) $display("FAIL fwft_capture: got data=%h empty=%b want 0badf00d/1", fs, fifo_empty); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] fs, fexp; logic [3:0] ls, lexp;
    logic fw, fr, lw, lr, fpop, lpop;
    int idx;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fw = ($urandom_range(0, 99) < 55);
      fr = ($urandom_range(0, 99) < 45);
      lr = ($urandom_range(0, 99) < 50);
      lw = (held.size() != 0) && ($urandom_range(0, 99) < 50);
      idx = (held.size() != 0) ? $urandom_range(0, held.size() - 1) : 0;
      fpop = fr && fq.size() != 0;
      lpop = lr && lq.size() != 0;
      fexp = fpop ? fq[0] : 32'd0;
      lexp = lpop ? lq[0] : 4'd0;
      cycle(fw, $urandom, fr, lw, lw ? held[idx] : 4'd0, lr, fs, ls);
      if (lw) held.delete(idx);
      if (lpop) held.push_back(ls);
      if (fpop) begin
        n_total++; if (fs !== fexp) $display("FAIL rand_fifo_data[%0d]: got %h want %h", i, fs, fexp); else n_pass++;
      end
      if (lpop) begin
        n_total++; if (ls !== lexp) $display("FAIL rand_fl_id[%0d]: got %0d want %0d", i, ls, lexp); else n_pass++;
      end
      n_total++; if (fifo_size !== 5'(fq.size()) || fifo_full !== (fq.size() == 16) || fifo_empty !== (fq.size() == 0))
        $display("FAIL rand_fifo_flags[%0d]: got size=%0d full=%b empty=%b want size=%0d", i, fifo_size, fifo_full, fifo_empty, fq.size());
      else n_pass++;
      n_total++; if (fl_full !== (lq.size() == 16) || fl_empty !== (lq.size() == 0))
        $display("FAIL rand_fl_flags[%0d]: got full=%b empty=%b want occupancy %0d", i, fl_full, fl_empty, lq.size());
      else n_pass++;
    end
  endtask

  initial begin
    rstn = 1'b1;
    fifo_wr_en = 1'b0; fifo_rd_en = 1'b0; fifo_wr_data = '0;
    fl_wr_en = 1'b0; fl_rd_en = 1'b0; fl_wr_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_free_list();
    test_fwft();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
